// File: rtl/gpio_seg7_scan_if.sv
// gpio_seg7_if
//   Bundles the GPIO-to-display signals between the CPU side and the scan block.
//   master : CPU/GPIO side. Drives data_in, dp_in and blank_en. Receives the display pins.
//   slave  : display scanner. Receives data_in, dp_in and blank_en. Drives an, seg, dp and frame_done.
//   data_in    32  GPIO output word; nibble k drives digit k (0 = rightmost)
//   dp_in      8   decimal-point enables, bit k -> digit k (1 = lit)
//   blank_en   1   1 = blank leading zeros
//   an         8   anode selects, active-low
//   seg        7   segments {g,f,e,d,c,b,a}, active-low
//   dp         1   decimal point, active-low
//   frame_done 1   one-cycle pulse at each frame end / shadow reload
interface gpio_seg7_if;
    logic [31:0] data_in;
    logic [7:0]  dp_in;
    logic        blank_en;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    modport master (
        output data_in, dp_in, blank_en,
        input  an, seg, dp, frame_done
    );

    modport slave (
        input  data_in, dp_in, blank_en,
        output an, seg, dp, frame_done
    );
endinterface

// File: rtl/gpio_seg7_scan.sv
// gpio_seg7_scan
//   Time-multiplexes the eight hex nibbles of the CPU GPIO word onto an 8-digit
//   common-anode seven-segment display. The block blanks leading zeros and keeps
//   each digit dark for a short guard time at the start of its window, so the
//   previous digit does not ghost onto the next one. The GPIO word is shadowed
//   only at frame ends, which keeps a write in the middle of a scan from tearing
//   the displayed value.
//   Parameters:
//     DIGIT_CYCLES  clk cycles per digit window (>= 4)
//     GUARD         dark cycles at the start of each window (< DIGIT_CYCLES)
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous active-high reset
//     bus  gpio_seg7_if.slave (data_in/dp_in/blank_en in; an/seg/dp/frame_done out)
module gpio_seg7_scan #(
    parameter int DIGIT_CYCLES = 100000,
    parameter int GUARD        = 4
) (
    input  logic          clk,
    input  logic          rst,
    gpio_seg7_if.slave    bus
);
    localparam int CNT_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIGIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GUARD_C = CNT_W'(GUARD);

    // Active-low {g,f,e,d,c,b,a} glyphs for hex digits.
    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    // A digit is a leading zero when it and every nibble above it are zero.
    // Digit 0 always shows, so an all-zero word still reads "0".
    function automatic logic digit_blanked(input logic [31:0] word, input logic [2:0] d,
                                           input logic en);
        logic [31:0] upper;
        upper = word >> {d, 2'b00};
        digit_blanked = en && (d != 3'd0) && (upper == 32'h0);
    endfunction

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       digit_q, digit_d;
    logic [31:0]      shadow_data_q, shadow_data_d;
    logic [7:0]       shadow_dp_q, shadow_dp_d;
    logic [7:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic             frame_done_q, frame_done_d;

    logic             win_end;
    logic             frame_end;
    logic             lit;
    logic [3:0]       nibble;

    always_comb begin
        win_end   = (cnt_q == CNT_MAX);
        frame_end = win_end && (digit_q == 3'd7);

        cnt_d   = win_end ? '0 : cnt_q + CNT_W'(1);
        digit_d = win_end ? digit_q + 3'd1 : digit_q;

        shadow_data_d = frame_end ? bus.data_in : shadow_data_q;
        shadow_dp_d   = frame_end ? bus.dp_in   : shadow_dp_q;
        frame_done_d  = frame_end;

        // The outputs are derived from the current state, so every pin is one cycle behind it.
        nibble = shadow_data_q[{digit_q, 2'b00} +: 4];
        lit    = (cnt_q >= GUARD_C) && !digit_blanked(shadow_data_q, digit_q, bus.blank_en);

        an_d  = lit ? ~(8'd1 << digit_q)     : 8'hFF;
        seg_d = lit ? hex7(nibble)           : 7'h7F;
        dp_d  = lit ? ~shadow_dp_q[digit_q]  : 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q         <= '0;
            digit_q       <= 3'd0;
            shadow_data_q <= 32'h0;
            shadow_dp_q   <= 8'h0;
            an_q          <= 8'hFF;
            seg_q         <= 7'h7F;
            dp_q          <= 1'b1;
            frame_done_q  <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            digit_q       <= digit_d;
            shadow_data_q <= shadow_data_d;
            shadow_dp_q   <= shadow_dp_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.frame_done = frame_done_q;
endmodule
